// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared widths, types and constants for the 32x32 register bank
package reg_bank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - register bank access bus: selectors, write data, strobes, read data
interface reg_bank_if;
    import reg_bank_pkg::*;

    reg_idx_t  regSelSrc0;
    reg_idx_t  regSelSrc1;
    reg_idx_t  regSelDst;
    reg_word_t regDst;
    logic      RDWRBar;
    logic      CSBar;
    reg_word_t regSrc0;
    reg_word_t regSrc1;

    modport master (
        output regSelSrc0,
        output regSelSrc1,
        output regSelDst,
        output regDst,
        output RDWRBar,
        output CSBar,
        input  regSrc0,
        input  regSrc1
    );

    modport slave (
        input  regSelSrc0,
        input  regSelSrc1,
        input  regSelDst,
        input  regDst,
        input  RDWRBar,
        input  CSBar,
        output regSrc0,
        output regSrc1
    );

endinterface

// File: rtl/reg_bank_rd_port.sv
// rtl/reg_bank_rd_port.sv - registered 32:1 read mux with index-0 forcing and hold when not reading
module reg_bank_rd_port
    import reg_bank_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rd_en_i,
    input  reg_idx_t  sel_i,
    input  reg_word_t mem_i [DEPTH],
    output reg_word_t data_o
);

    reg_word_t data_q;
    reg_word_t data_d;

    // The selector is only looked at when reading, so garbage on it while idle cannot leak in.
    always_comb begin
        data_d = data_q;
        if (rd_en_i) begin
            data_d = (sel_i == ZERO_REG) ? '0 : mem_i[sel_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/reg_bank_32.sv
// rtl/reg_bank_32.sv - 32-entry x 32-bit register file, one write port and two registered read ports
module reg_bank_32
    import reg_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);

    reg_word_t mem_q [DEPTH];
    logic      wr_en;
    logic      rd_en;
    logic      wr_hit;
    reg_word_t src0_data;
    reg_word_t src1_data;

    assign wr_en  = ~bus.CSBar & ~bus.RDWRBar;
    assign rd_en  = ~bus.CSBar &  bus.RDWRBar;
    assign wr_hit = wr_en && (bus.regSelDst != ZERO_REG);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[bus.regSelDst] <= bus.regDst;
        end
    end

    reg_bank_rd_port u_rd_port0 (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (rd_en),
        .sel_i   (bus.regSelSrc0),
        .mem_i   (mem_q),
        .data_o  (src0_data)
    );

    reg_bank_rd_port u_rd_port1 (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (rd_en),
        .sel_i   (bus.regSelSrc1),
        .mem_i   (mem_q),
        .data_o  (src1_data)
    );

    assign bus.regSrc0 = src0_data;
    assign bus.regSrc1 = src1_data;

endmodule

// File: tb/tb_reg_bank_32.sv
// tb/tb_reg_bank_32.sv - self-checking bench for reg_bank_32 against a behavioural array model
module tb_reg_bank_32;

    logic clk;
    logic rst;

    reg_bank_if bus ();

    reg_bank_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] model [32];
    logic [31:0] exp0;
    logic [31:0] exp1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        exp0 = 32'h0;
        exp1 = 32'h0;
    endtask

    // One bus cycle: drive, clock, update the model from the access rules, compare both ports.
    task automatic bus_cycle(input logic cs_bar, input logic rdwr_bar,
                             input logic [4:0] s0, input logic [4:0] s1,
                             input logic [4:0] dst, input logic [31:0] wdata,
                             input string tag);
        bus.CSBar      = cs_bar;
        bus.RDWRBar    = rdwr_bar;
        bus.regSelSrc0 = s0;
        bus.regSelSrc1 = s1;
        bus.regSelDst  = dst;
        bus.regDst     = wdata;
        @(posedge clk);
        #1;
        if (!cs_bar && rdwr_bar) begin
            exp0 = model[s0];
            exp1 = model[s1];
        end else if (!cs_bar && !rdwr_bar && dst != 5'd0) begin
            model[dst] = wdata;
        end
        check_eq({tag, "/src0"}, bus.regSrc0, exp0);
        check_eq({tag, "/src1"}, bus.regSrc1, exp1);
    endtask

    task automatic wr(input logic [4:0] dst, input logic [31:0] d, input string tag);
        bus_cycle(1'b0, 1'b0, 5'd0, 5'd0, dst, d, tag);
    endtask

    task automatic rd(input logic [4:0] s0, input logic [4:0] s1, input string tag);
        bus_cycle(1'b0, 1'b1, s0, s1, 5'd0, 32'h0, tag);
    endtask

    task automatic idle(input string tag);
        bus_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, tag);
    endtask

    // Pulse rst between clock edges and check that outputs clear without any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq({tag, "/src0_async"}, bus.regSrc0, 32'h0);
        check_eq({tag, "/src1_async"}, bus.regSrc1, 32'h0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst            = 1'b1;
        bus.CSBar      = 1'b1;
        bus.RDWRBar    = 1'b1;
        bus.regSelSrc0 = 5'd0;
        bus.regSelSrc1 = 5'd0;
        bus.regSelDst  = 5'd0;
        bus.regDst     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset/src0", bus.regSrc0, 32'h0);
        check_eq("reset/src1", bus.regSrc1, 32'h0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        rd(5'd17, 5'd31, "reset_read");

        wr(5'd3, 32'hFAEAFAEA, "w_r3");
        idle("idle_after_w_r3");
        rd(5'd3, 5'd0, "r_r3");
        check_eq("r3_direct", bus.regSrc0, 32'hFAEAFAEA);
        idle("hold_r3");
        check_eq("r3_hold", bus.regSrc0, 32'hFAEAFAEA);
        wr(5'd12, 32'h0BADF00D, "w_hold");
        check_eq("r3_hold_during_write", bus.regSrc0, 32'hFAEAFAEA);

        bus_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345678, "cs_gated_w_r5");
        rd(5'd5, 5'd5, "r_r5");
        check_eq("r5_gated", bus.regSrc0, 32'h0);

        wr(5'd7, 32'hA5A5A5A5, "w_r7");
        wr(5'd9, 32'h5A5A5A5A, "w_r9");
        rd(5'd7, 5'd9, "dual_read");
        check_eq("dual_r7", bus.regSrc0, 32'hA5A5A5A5);
        check_eq("dual_r9", bus.regSrc1, 32'h5A5A5A5A);
        rd(5'd7, 5'd7, "same_idx");
        check_eq("same_p1", bus.regSrc1, 32'hA5A5A5A5);

        wr(5'd0, 32'hFFFFFFFF, "w_x0");
        rd(5'd0, 5'd0, "r_x0");
        check_eq("x0_p0", bus.regSrc0, 32'h0);
        check_eq("x0_p1", bus.regSrc1, 32'h0);

        wr(5'd20, 32'h11111111, "w_r20_a");
        wr(5'd20, 32'h22222222, "w_r20_b");
        rd(5'd20, 5'd31, "last_wins");
        check_eq("last_wins_r20", bus.regSrc0, 32'h22222222);

        wr(5'd3, 32'hFAEAFAEA, "refill_r3");
        rd(5'd3, 5'd3, "pre_rst_r3");
        async_reset("mid_op");
        @(posedge clk);
        #1;
        rd(5'd3, 5'd7, "post_rst_r3");
        check_eq("post_rst_r3_zero", bus.regSrc0, 32'h0);

        // Random traffic; selectors are scrambled freely on idle cycles.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[3:0] == 4'd0) begin
                bus_cycle(1'b1, r[4], 5'($urandom), 5'($urandom), 5'($urandom), $urandom, "rnd_idle");
            end else if (r[5]) begin
                rd(5'($urandom), 5'($urandom), "rnd_rd");
            end else begin
                wr((r[8:6] == 3'd0) ? 5'd0 : 5'($urandom), $urandom, "rnd_wr");
            end
            if (i == 300) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
